// File: rtl/rst_seq_if.sv
// Handshake bundle between the staged reset sequencer and the stages it releases.
// master = sequencer side, slave = stage/controller side.
interface rst_seq_if #(
    parameter int NumStages = 4
);
    localparam int IdxW = (NumStages > 1) ? $clog2(NumStages) : 1;

    logic                 sw_rst_i;
    logic [NumStages-1:0] stage_ack_i;
    logic [NumStages-1:0] stage_rst_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 timeout_o;
    logic [IdxW-1:0]      timeout_stage_o;

    modport master (
        input  sw_rst_i,
        input  stage_ack_i,
        output stage_rst_o,
        output busy_o,
        output done_o,
        output timeout_o,
        output timeout_stage_o
    );

    modport slave (
        output sw_rst_i,
        output stage_ack_i,
        input  stage_rst_o,
        input  busy_o,
        input  done_o,
        input  timeout_o,
        input  timeout_stage_o
    );
endinterface

// File: rtl/rst_seq.sv
// Staged reset-release sequencer: releases one stage at a time, waits for its ack,
// inserts a fixed gap before the next stage, and reports done or the stage that timed out.
module rst_seq #(
    parameter int NumStages  = 4,
    parameter int GapCycles  = 8,
    parameter int AckTimeout = 256
) (
    input  logic          clk_i,
    input  logic          rst_i,
    rst_seq_if.master     bus
);
    localparam int IdxW   = (NumStages > 1) ? $clog2(NumStages) : 1;
    localparam int CntMax = (GapCycles > AckTimeout) ? GapCycles : AckTimeout;
    localparam int CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] GapLast   = CntW'(GapCycles - 1);
    localparam logic [CntW-1:0] AckLast   = CntW'((AckTimeout > 0) ? AckTimeout - 1 : 0);
    localparam logic [IdxW-1:0] LastIdx   = IdxW'(NumStages - 1);
    localparam bit              TimeoutEn = (AckTimeout != 0);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT_ACK,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_t;

    state_t               state_reg, state_next;
    logic [CntW-1:0]      cnt_reg, cnt_next;
    logic [IdxW-1:0]      k_reg, k_next;
    logic [NumStages-1:0] stage_rst_reg, stage_rst_next;
    logic                 busy_reg, busy_next;
    logic                 done_reg, done_next;
    logic                 timeout_reg, timeout_next;
    logic [IdxW-1:0]      timeout_stage_reg, timeout_stage_next;

    logic                 ack_k;
    logic                 rel_en;
    logic                 fault_en;

    assign ack_k = bus.stage_ack_i[k_reg];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg         <= S_HOLD;
            cnt_reg           <= '0;
            k_reg             <= '0;
            stage_rst_reg     <= '1;
            busy_reg          <= 1'b1;
            done_reg          <= 1'b0;
            timeout_reg       <= 1'b0;
            timeout_stage_reg <= '0;
        end else begin
            state_reg         <= state_next;
            cnt_reg           <= cnt_next;
            k_reg             <= k_next;
            stage_rst_reg     <= stage_rst_next;
            busy_reg          <= busy_next;
            done_reg          <= done_next;
            timeout_reg       <= timeout_next;
            timeout_stage_reg <= timeout_stage_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        k_next     = k_reg;
        rel_en     = 1'b0;
        fault_en   = 1'b0;

        if (bus.sw_rst_i) begin
            state_next = S_HOLD;
            cnt_next   = '0;
            k_next     = '0;
        end else begin
            case (state_reg)
                S_HOLD: begin
                    if (cnt_reg == GapLast) begin
                        state_next = S_WAIT_ACK;
                        cnt_next   = '0;
                        rel_en     = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CntW'(1);
                    end
                end
                S_WAIT_ACK: begin
                    // An ack arriving on the timeout edge takes precedence over the fault.
                    if (ack_k) begin
                        cnt_next   = '0;
                        state_next = (k_reg == LastIdx) ? S_DONE : S_GAP;
                    end else if (TimeoutEn && (cnt_reg == AckLast)) begin
                        state_next = S_FAULT;
                        fault_en   = 1'b1;
                    end else if (cnt_reg != '1) begin
                        cnt_next = cnt_reg + CntW'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_reg == GapLast) begin
                        state_next = S_WAIT_ACK;
                        cnt_next   = '0;
                        k_next     = k_reg + IdxW'(1);
                        rel_en     = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CntW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Each stage reset only changes on restart, its own release, or a fault on it.
    for (genvar gi = 0; gi < NumStages; gi++) begin : g_stage
        assign stage_rst_next[gi] =
            bus.sw_rst_i                                  ? 1'b1 :
            (rel_en   && (k_next == IdxW'(gi)))           ? 1'b0 :
            (fault_en && (k_reg  == IdxW'(gi)))           ? 1'b1 :
                                                            stage_rst_reg[gi];
    end

    always_comb begin
        busy_next          = (state_next != S_DONE) && (state_next != S_FAULT);
        done_next          = (state_next == S_DONE);
        timeout_next       = (state_next == S_FAULT);
        timeout_stage_next = (state_next == S_FAULT) ? k_next : '0;
    end

    assign bus.stage_rst_o     = stage_rst_reg;
    assign bus.busy_o          = busy_reg;
    assign bus.done_o          = done_reg;
    assign bus.timeout_o       = timeout_reg;
    assign bus.timeout_stage_o = timeout_stage_reg;
endmodule

// File: doc/rst_seq.md
# rst_seq

Staged reset-release sequencer that sits directly downstream of the testbench clock/reset generator. It takes the global clock and reset and deasserts a set of per-stage resets one stage at a time. Between stages it inserts a fixed gap and waits for each stage to acknowledge that it is alive. It reports completion, or a timeout naming the stage that failed to acknowledge.

## Interface
- NumStages, 4: number of reset stages, ≥1.
- GapCycles, 8: hold/gap length in cycles, ≥1.
- AckTimeout, 256: maximum cycles to wait for a stage ack; 0 disables the timeout.
- clk_i  input  1  clock.
- rst_i  input  1  reset, synchronous, active-high.
- sw_rst_i  input  1  synchronous restart request; level is sampled on each edge.
- stage_ack_i  input  NumStages  per-stage "out of reset" ack.
- stage_rst_o  output  NumStages  per-stage reset, active-high, registered.
- busy_o  output  1  sequence in progress.
- done_o  output  1  all stages released and acknowledged.
- timeout_o  output  1  ack timeout occurred.
- timeout_stage_o  output  max(1,$clog2(NumStages))  index of the stage that timed out.

## Operation
- Clock and reset: one clock, clk_i. Reset is rst_i, synchronous and active-high; it has priority over everything else.
- Reset values: stage_rst_o all 1, busy_o 1, done_o 0, timeout_o 0, timeout_stage_o 0, FSM in HOLD, counter 0, stage index k = 0.
- FSM states:
  - HOLD: counts GapCycles edges with all stages held in reset, then deasserts stage_rst_o[0] and goes to WAIT_ACK.
  - WAIT_ACK: samples stage_ack_i[k] only.
    - Ack high and k < NumStages-1: go to GAP, counter cleared.
    - Ack high and k = NumStages-1: go to DONE.
    - Ack low: increment the timeout counter. When AckTimeout consecutive low samples are reached (AckTimeout ≠ 0), go to FAULT.
  - GAP: counts GapCycles edges, then increments k, deasserts stage_rst_o[k] and goes to WAIT_ACK.
  - DONE: done_o=1, busy_o=0. Terminal state.
  - FAULT: timeout_o=1, timeout_stage_o=k. stage_rst_o[k] is reasserted; stages >k remain asserted and stages <k stay released. busy_o=0, done_o=0. Terminal state.
- Acks for stages other than k are ignored. A stage_ack_i[k] drop after it has been sampled is ignored.
- sw_rst_i high on an edge, in any state:
  - Next state is HOLD and all stage_rst_o return to 1.
  - busy_o=1; done_o, timeout_o, counter and k are cleared.
  - This is identical to rst_i except for priority.
- Once a stage is released, stage_rst_o[k] is never reasserted except on rst_i, sw_rst_i or a fault on that stage.
- Counter width is $clog2(max(GapCycles, AckTimeout)+1). The counter never wraps and saturates at its terminal count.

## Timing
- Edge numbering: edge 1 is the first rising edge at which rst_i is sampled low.
- stage_rst_o[0] falls after edge GapCycles.
- Stage release spacing:
  - If stage k's ack is first sampled high at edge e, stage k+1 is released after edge e+GapCycles.
  - With acks tied high, spacing is GapCycles+1 cycles.
- DONE is entered on the edge that samples the last stage's ack high. done_o rises and busy_o falls after that edge, zero added cycles.
- Timeout: stage k is released at edge r. FAULT is entered on edge r+AckTimeout if ack is sampled low on edges r+1..r+AckTimeout.
- An ack that rises on exactly the timeout edge wins: no fault.
- Restart/reset latency: rst_i or sw_rst_i sampled high at edge n gives reset values visible after edge n.
- Ready-to-start: the sequence restarts with edge n+1 counted as edge 1.
- All outputs are registered, with no combinational input-to-output paths.

## Test plan
All scenarios use NumStages=4, GapCycles=8, AckTimeout=16 unless stated otherwise.
- Nominal, acks tied high:
  - stage_rst_o[0..3] fall after edges 8, 17, 26, 35.
  - done_o=1 and busy_o=0 after edge 36.
- Late ack: stage_ack_i[1] first high at edge 25 -> stage_rst_o[2] falls after edge 33, stage 3 after edge 42.
- Timeout: stage_ack_i[2] held low, stage 2 released at edge 26.
  - After edge 42: timeout_o=1, timeout_stage_o=2, stage_rst_o=4'b1100, busy_o=0, done_o=0.
  - The state holds until a restart.
- Timeout boundary: stage_ack_i[2] first high at edge 42 -> no fault; stage 3 released after edge 50.
- Restart from DONE and mid-sequence:
  - sw_rst_i pulsed at edge 50 -> all stage_rst_o=1 and busy_o=1 after edge 50; stage 0 re-released after edge 58.
  - rst_i high at edge 20 -> reset values after edge 20.
  - rst_i and sw_rst_i together -> reset values.
- Disabled timeout (AckTimeout=0): ack low for 1000 cycles -> no fault, busy_o stays 1. A later ack completes the sequence normally.
